// File: rtl/evo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evo_pkg
// Description : Shared types and constants for the population evaluation
//               scheduler: error-sum geometry, fitness width, the packed
//               error-sum array type and the scheduler state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package evo_pkg;

   localparam int ERR_LANES = 8;
   localparam int ERR_W     = 32;
   // 8 lanes of 32 bits need 3 extra bits for a wrap-free sum
   localparam int FIT_W     = 35;

   typedef logic [ERR_LANES-1:0][ERR_W-1:0] err_sums_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FLUSH     = 3'd1,
      S_SELECT    = 3'd2,
      S_START     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_ACCUM     = 3'd5,
      S_ACK       = 3'd6,
      S_FINISH    = 3'd7
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fitness_adder.sv
`default_nettype none
// ============================================================================
// Module      : fitness_adder
// Description : Combinational reduction of the eight 32-bit evaluator error
//               lanes into one 35-bit fitness value (zero-extended sum).
// Ports       : iSums    - captured per-output error sums
//               oFitness - sum of all lanes
// Revision    : 1.0 - initial release
// ============================================================================
module fitness_adder
   import evo_pkg::*;
(
   input  err_sums_t        iSums,
   output logic [FIT_W-1:0] oFitness
);

   always_comb begin
      oFitness = '0;
      for (int i = 0; i < ERR_LANES; i++) begin
         oFitness = oFitness + FIT_W'(iSums[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/population_evaluation_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : population_evaluation_scheduler
// Description : Walks the evaluator across one generation of chromosomes:
//               selects each index, starts the evaluator, captures its error
//               sums, writes the reduced fitness to the fitness memory and
//               tracks the lowest fitness seen.
// Ports       : iClock / iReset           - clock, async active-high reset
//               iStartGeneration          - start pulse (ignored when busy)
//               iPopulationSize           - chromosomes to evaluate
//               iStopOnZero               - end early on zero fitness
//               iReadyToProcess           - evaluator idle
//               iDoneProcessing           - evaluator result valid
//               iErrorSums                - evaluator per-output error sums
//               oStartProcessing          - start request to evaluator
//               oDoneProcessingFeedback   - result acknowledge to evaluator
//               oChromSelect              - chromosome under evaluation
//               oFitnessWrEn/Addr/Data    - fitness memory write port
//               oBestIndex / oBestFitness - best chromosome so far
//               oBusy / oGenerationDone   - status and end-of-generation pulse
// Revision    : 1.0 - initial release
// ============================================================================
module population_evaluation_scheduler
   import evo_pkg::*;
#(
   parameter int POP_SIZE = 16,
   parameter int IDX_W    = $clog2(POP_SIZE)
)(
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iStartGeneration,
   input  logic [IDX_W:0]   iPopulationSize,
   input  logic             iStopOnZero,
   input  logic             iReadyToProcess,
   input  logic             iDoneProcessing,
   input  err_sums_t        iErrorSums,
   output logic             oStartProcessing,
   output logic             oDoneProcessingFeedback,
   output logic [IDX_W-1:0] oChromSelect,
   output logic             oFitnessWrEn,
   output logic [IDX_W-1:0] oFitnessAddr,
   output logic [FIT_W-1:0] oFitnessData,
   output logic [IDX_W-1:0] oBestIndex,
   output logic [FIT_W-1:0] oBestFitness,
   output logic             oBusy,
   output logic             oGenerationDone
);

   localparam logic [IDX_W:0] c_popSize = (IDX_W+1)'(POP_SIZE);

   sched_state_t     r_state;
   sched_state_t     w_stateNext;
   logic [IDX_W-1:0] r_index;
   logic [IDX_W-1:0] w_indexInc;
   logic [IDX_W-1:0] w_selectIndex;
   logic [IDX_W-1:0] r_chromSelect;
   logic [IDX_W:0]   r_count;
   logic [IDX_W:0]   w_countClamped;
   logic             r_stopOnZero;
   err_sums_t        r_sums;
   logic [FIT_W-1:0] w_fitness;
   logic [FIT_W-1:0] r_bestFitness;
   logic [IDX_W-1:0] r_bestIndex;
   logic             w_lastIndex;
   logic             w_stopHit;

   fitness_adder u_fitnessAdder (
      .iSums    (r_sums),
      .oFitness (w_fitness)
   );

   assign w_countClamped = (iPopulationSize > c_popSize) ? c_popSize : iPopulationSize;
   assign w_indexInc     = r_index + IDX_W'(1);
   // count is at least 1 whenever ACK is reached, so count-1 never wraps there
   assign w_lastIndex    = ({1'b0, r_index} == (r_count - (IDX_W+1)'(1)));
   assign w_stopHit      = r_stopOnZero && (w_fitness == '0);

   // The selected index is loaded only on entry to SELECT so the evaluator
   // sees a stable chromosome from SELECT through ACK.
   assign w_selectIndex  = (r_state == S_ACK)  ? w_indexInc :
                           (r_state == S_IDLE) ? '0 : r_index;

   // ---------------------------------------------------------------- state
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // ------------------------------------------------ next state / outputs
   always_comb begin
      w_stateNext             = r_state;
      oStartProcessing        = 1'b0;
      oDoneProcessingFeedback = 1'b0;
      oFitnessWrEn            = 1'b0;
      oFitnessAddr            = '0;
      oFitnessData            = '0;
      oGenerationDone         = 1'b0;
      oBusy                   = (r_state != S_IDLE);
      oChromSelect            = r_chromSelect;
      oBestIndex              = r_bestIndex;
      oBestFitness            = r_bestFitness;

      case (r_state)
         S_IDLE: begin
            if (iStartGeneration) begin
               if (w_countClamped == '0) begin
                  w_stateNext = S_FINISH;
               end else if (iDoneProcessing) begin
                  // evaluator still holds a result from an aborted run
                  w_stateNext = S_FLUSH;
               end else begin
                  w_stateNext = S_SELECT;
               end
            end
         end
         S_FLUSH: begin
            oDoneProcessingFeedback = 1'b1;
            w_stateNext             = S_SELECT;
         end
         S_SELECT: begin
            w_stateNext = S_START;
         end
         S_START: begin
            oStartProcessing = 1'b1;
            if (iReadyToProcess) begin
               w_stateNext = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (iDoneProcessing) begin
               w_stateNext = S_ACCUM;
            end
         end
         S_ACCUM: begin
            oFitnessWrEn = 1'b1;
            oFitnessAddr = r_index;
            oFitnessData = w_fitness;
            w_stateNext  = S_ACK;
         end
         S_ACK: begin
            oDoneProcessingFeedback = 1'b1;
            w_stateNext = (w_lastIndex || w_stopHit) ? S_FINISH : S_SELECT;
         end
         S_FINISH: begin
            oGenerationDone = 1'b1;
            w_stateNext     = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_index       <= '0;
         r_count       <= '0;
         r_stopOnZero  <= 1'b0;
         r_sums        <= '0;
         r_bestFitness <= '0;
         r_bestIndex   <= '0;
         r_chromSelect <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iStartGeneration) begin
                  r_count       <= w_countClamped;
                  r_stopOnZero  <= iStopOnZero;
                  r_index       <= '0;
                  r_bestFitness <= '1;
                  r_bestIndex   <= '0;
               end
            end
            S_WAIT_DONE: begin
               if (iDoneProcessing) begin
                  r_sums <= iErrorSums;
               end
            end
            S_ACCUM: begin
               // strict compare: on ties the earlier (lower) index is kept
               if (w_fitness < r_bestFitness) begin
                  r_bestFitness <= w_fitness;
                  r_bestIndex   <= r_index;
               end
            end
            S_ACK: begin
               if (w_stateNext == S_SELECT) begin
                  r_index <= w_indexInc;
               end
            end
            default: begin
            end
         endcase

         if ((w_stateNext == S_SELECT) && (r_state != S_SELECT)) begin
            r_chromSelect <= w_selectIndex;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_population_evaluation_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_population_evaluation_scheduler
// Description : Directed bench for population_evaluation_scheduler with a
//               behavioural evaluator (configurable latency and ready hold)
//               and a write/handshake monitor.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_population_evaluation_scheduler;
   import evo_pkg::*;

   localparam int POP_SIZE = 16;
   localparam int IDX_W    = 4;

   logic             iClock           = 1'b0;
   logic             iReset           = 1'b1;
   logic             iStartGeneration = 1'b0;
   logic [IDX_W:0]   iPopulationSize  = '0;
   logic             iStopOnZero      = 1'b0;
   logic             iReadyToProcess  = 1'b1;
   logic             iDoneProcessing  = 1'b0;
   err_sums_t        iErrorSums       = '0;
   logic             oStartProcessing;
   logic             oDoneProcessingFeedback;
   logic [IDX_W-1:0] oChromSelect;
   logic             oFitnessWrEn;
   logic [IDX_W-1:0] oFitnessAddr;
   logic [FIT_W-1:0] oFitnessData;
   logic [IDX_W-1:0] oBestIndex;
   logic [FIT_W-1:0] oBestFitness;
   logic             oBusy;
   logic             oGenerationDone;

   population_evaluation_scheduler #(.POP_SIZE(POP_SIZE), .IDX_W(IDX_W)) dut (
      .iClock                  (iClock),
      .iReset                  (iReset),
      .iStartGeneration        (iStartGeneration),
      .iPopulationSize         (iPopulationSize),
      .iStopOnZero             (iStopOnZero),
      .iReadyToProcess         (iReadyToProcess),
      .iDoneProcessing         (iDoneProcessing),
      .iErrorSums              (iErrorSums),
      .oStartProcessing        (oStartProcessing),
      .oDoneProcessingFeedback (oDoneProcessingFeedback),
      .oChromSelect            (oChromSelect),
      .oFitnessWrEn            (oFitnessWrEn),
      .oFitnessAddr            (oFitnessAddr),
      .oFitnessData            (oFitnessData),
      .oBestIndex              (oBestIndex),
      .oBestFitness            (oBestFitness),
      .oBusy                   (oBusy),
      .oGenerationDone         (oGenerationDone)
   );

   always #5 iClock = ~iClock;

   int total = 0;
   int bad   = 0;

   // evaluator model
   err_sums_t        sumTable [POP_SIZE];
   int               evLatency = 10;
   int               evHold    = 0;
   int               evPhase   = 0;
   int               evCnt     = 0;
   logic             evPend    = 1'b0;
   logic [IDX_W-1:0] evSel     = '0;

   // monitor
   int               cyc         = 0;
   int               wrCnt       = 0;
   int               doneCnt     = 0;
   int               startCycles = 0;
   int               fbCycles    = 0;
   int               overlapCnt  = 0;
   int               firstFb     = -1;
   int               firstStart  = -1;
   logic [IDX_W-1:0] wrAddr [64];
   logic [FIT_W-1:0] wrData [64];

   // Evaluator: accepts a start when it drives ready high during START,
   // returns sumTable[selected] after evLatency cycles, holds done until
   // feedback is seen.
   initial forever begin
      @(negedge iClock);
      case (evPhase)
         0: begin
            if (evPend) begin
               evPend          = 1'b0;
               evPhase         = 1;
               evCnt           = evLatency;
               iReadyToProcess = 1'b0;
            end else if (oStartProcessing) begin
               if (evHold > 0) begin
                  evHold--;
                  iReadyToProcess = 1'b0;
               end else begin
                  iReadyToProcess = 1'b1;
                  evPend          = 1'b1;
                  evSel           = oChromSelect;
               end
            end
         end
         1: begin
            evCnt--;
            if (evCnt <= 0) begin
               iErrorSums      = sumTable[evSel];
               iDoneProcessing = 1'b1;
               evPhase         = 2;
            end
         end
         2: begin
            if (oDoneProcessingFeedback) begin
               iDoneProcessing = 1'b0;
               iReadyToProcess = 1'b1;
               evPhase         = 0;
            end
         end
         default: evPhase = 0;
      endcase
   end

   initial forever begin
      @(negedge iClock);
      cyc++;
      if (oFitnessWrEn) begin
         if (wrCnt < 64) begin
            wrAddr[wrCnt] = oFitnessAddr;
            wrData[wrCnt] = oFitnessData;
         end
         wrCnt++;
      end
      if (oGenerationDone) doneCnt++;
      if (oStartProcessing) begin
         startCycles++;
         if (firstStart < 0) firstStart = cyc;
      end
      if (oDoneProcessingFeedback) begin
         fbCycles++;
         if (firstFb < 0) firstFb = cyc;
      end
      if (oStartProcessing && oDoneProcessingFeedback) overlapCnt++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clearMon();
      wrCnt       = 0;
      doneCnt     = 0;
      startCycles = 0;
      fbCycles    = 0;
      firstFb     = -1;
      firstStart  = -1;
   endtask

   task automatic clearTable();
      for (int i = 0; i < POP_SIZE; i++) sumTable[i] = '0;
   endtask

   task automatic launch(input int size, input logic stop);
      clearMon();
      iPopulationSize  = (IDX_W+1)'(size);
      iStopOnZero      = stop;
      iStartGeneration = 1'b1;
      @(negedge iClock);
      iStartGeneration = 1'b0;
   endtask

   task automatic waitGenDone(input int budget);
      int n = 0;
      while (doneCnt == 0 && n < budget) begin
         @(negedge iClock);
         n++;
      end
      repeat (3) @(negedge iClock);
      chk("gen_done_within_budget", (doneCnt != 0), 1);
   endtask

   initial begin
      int n;
      clearTable();

      // ---- reset state
      repeat (3) @(negedge iClock);
      chk("rst_busy",      oBusy, 0);
      chk("rst_start",     oStartProcessing, 0);
      chk("rst_fb",        oDoneProcessingFeedback, 0);
      chk("rst_wren",      oFitnessWrEn, 0);
      chk("rst_bestfit",   oBestFitness, 0);
      chk("rst_chromsel",  oChromSelect, 0);
      chk("rst_gendone",   oGenerationDone, 0);
      iReset = 1'b0;
      repeat (2) @(negedge iClock);

      // ---- basic generation: fitness 1,0,6,2
      sumTable[0][0] = 32'd1;
      sumTable[2][0] = 32'd3;
      sumTable[2][1] = 32'd3;
      sumTable[3][0] = 32'd2;
      launch(4, 1'b0);
      waitGenDone(2000);
      chk("basic_wrcnt", wrCnt, 4);
      chk("basic_addr0", wrAddr[0], 0);
      chk("basic_addr1", wrAddr[1], 1);
      chk("basic_addr2", wrAddr[2], 2);
      chk("basic_addr3", wrAddr[3], 3);
      chk("basic_data0", wrData[0], 1);
      chk("basic_data1", wrData[1], 0);
      chk("basic_data2", wrData[2], 6);
      chk("basic_data3", wrData[3], 2);
      chk("basic_bestidx", oBestIndex, 1);
      chk("basic_bestfit", oBestFitness, 0);
      chk("basic_donecnt", doneCnt, 1);
      chk("basic_busy_after", oBusy, 0);

      // ---- early stop on zero fitness
      launch(4, 1'b1);
      waitGenDone(2000);
      chk("stop_wrcnt", wrCnt, 2);
      chk("stop_addr1", wrAddr[1], 1);
      chk("stop_data1", wrData[1], 0);
      chk("stop_bestidx", oBestIndex, 1);
      chk("stop_donecnt", doneCnt, 1);

      // ---- ties and saturated lanes
      clearTable();
      sumTable[0][0] = 32'd5;
      sumTable[1][2] = 32'd5;
      sumTable[2]    = '1;
      sumTable[3][7] = 32'd5;
      launch(4, 1'b0);
      waitGenDone(2000);
      chk("tie_wrcnt", wrCnt, 4);
      chk("tie_sat_data", wrData[2], 64'h7_FFFF_FFF8);
      chk("tie_data3", wrData[3], 5);
      chk("tie_bestidx", oBestIndex, 0);
      chk("tie_bestfit", oBestFitness, 5);

      // ---- size 0: immediate done, no evaluator activity
      launch(0, 1'b0);
      chk("zero_gendone_pulse", oGenerationDone, 1);
      @(negedge iClock);
      chk("zero_gendone_clear", oGenerationDone, 0);
      chk("zero_idle", oBusy, 0);
      repeat (3) @(negedge iClock);
      chk("zero_no_start", startCycles, 0);
      chk("zero_no_write", wrCnt, 0);
      chk("zero_bestfit_init", oBestFitness, 64'h7_FFFF_FFFF);

      // ---- size 20 clamps to 16; fitness 20-i so best is index 15
      clearTable();
      for (int i = 0; i < POP_SIZE; i++) sumTable[i][i % 8] = 32'(20 - i);
      evLatency = 3;
      launch(20, 1'b0);
      waitGenDone(3000);
      chk("clamp_wrcnt", wrCnt, 16);
      chk("clamp_addr15", wrAddr[15], 15);
      chk("clamp_data0", wrData[0], 20);
      chk("clamp_data15", wrData[15], 5);
      chk("clamp_bestidx", oBestIndex, 15);
      chk("clamp_bestfit", oBestFitness, 5);

      // ---- ready held low 7 cycles in START; restart while busy ignored
      clearTable();
      sumTable[0][4] = 32'd7;
      evHold = 7;
      launch(1, 1'b0);
      repeat (3) @(negedge iClock);
      chk("hs_busy_mid", oBusy, 1);
      iStartGeneration = 1'b1;
      @(negedge iClock);
      iStartGeneration = 1'b0;
      waitGenDone(2000);
      chk("hs_start_cycles", startCycles, 8);
      chk("hs_wrcnt", wrCnt, 1);
      chk("hs_data0", wrData[0], 7);
      repeat (20) @(negedge iClock);
      chk("hs_no_restart_done", doneCnt, 1);
      chk("hs_no_restart_busy", oBusy, 0);

      // ---- reset during WAIT_DONE, then flush of the stale result
      evLatency = 10;
      launch(2, 1'b0);
      n = 0;
      while (evPhase != 1 && n < 100) begin
         @(negedge iClock);
         n++;
      end
      chk("rf_reached_wait", (evPhase == 1), 1);
      repeat (2) @(negedge iClock);
      iReset = 1'b1;
      #1;
      chk("rf_rst_busy",    oBusy, 0);
      chk("rst_rst_start",  oStartProcessing, 0);
      chk("rf_rst_bestfit", oBestFitness, 0);
      chk("rf_rst_chrom",   oChromSelect, 0);
      @(negedge iClock);
      iReset = 1'b0;
      n = 0;
      while (evPhase != 2 && n < 100) begin
         @(negedge iClock);
         n++;
      end
      repeat (2) @(negedge iClock);
      chk("rf_idle_with_stale", oBusy, 0);
      chk("rf_no_write", wrCnt, 0);
      chk("rf_no_gendone", doneCnt, 0);
      clearTable();
      sumTable[0][1] = 32'd9;
      launch(1, 1'b0);
      waitGenDone(2000);
      chk("rf_flush_before_start", (firstFb >= 0 && firstStart >= 0 && firstFb < firstStart), 1);
      chk("rf_fb_cycles", fbCycles, 2);
      chk("rf_wrcnt", wrCnt, 1);
      chk("rf_data0", wrData[0], 9);

      chk("never_start_and_fb", overlapCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
